skid_fifo: RTL
==============

SKID_FIFO -- requirements
Module: skid_fifo

Interface
REQ-001 Parameter DW, default 16: data width in bits, legal range 1..1024.
REQ-002 Parameter DEPTH, default 4: storage entries, power of two, legal range 2..256.
REQ-003 Parameter FALLTHROUGH, default 1: 1 = zero-latency bypass when empty; 0 = every beat passes through storage.
REQ-004 Parameter AF_LEVEL, default DEPTH-1: almost-full threshold, legal range 1..DEPTH.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  synchronous discard of all stored beats.
REQ-008 up_data  input  DW  upstream data.
REQ-009 up_valid  input  1  upstream beat valid.
REQ-010 up_ready  output  1  upstream accept; driven directly from a flop, no combinational path from any input.
REQ-011 down_data  output  DW  downstream data.
REQ-012 down_valid  output  1  downstream beat valid.
REQ-013 down_ready  input  1  downstream accept.
REQ-014 count  output  $clog2(DEPTH+1)  stored-entry occupancy, registered.
REQ-015 almost_full  output  1  registered; high when count >= AF_LEVEL.

Function
REQ-016 Upstream transfer (up_fire) occurs on a rising edge with up_valid=1 and up_ready=1; downstream transfer (down_fire) occurs with down_valid=1 and down_ready=1.
REQ-017 Storage is a circular buffer of DEPTH x DW with rd_ptr and wr_ptr of $clog2(DEPTH) bits; pointers wrap DEPTH-1 -> 0 with no bubble.
REQ-018 count_next = count + (store) - (pop), where store = up_fire and not bypass-consumed, pop = down_fire sourced from storage; count never exceeds DEPTH or drops below 0.
REQ-019 up_ready flop loads (count_next < DEPTH) each cycle, so up_ready=0 exactly in cycles where count=DEPTH.
REQ-020 Non-empty (count>0): down_valid=1, down_data = entry at rd_ptr, in both modes.
REQ-021 FALLTHROUGH=1 and count=0: down_valid = up_valid and up_ready, down_data = up_data; if down_ready=1 the beat bypasses with no write and count stays 0; if down_ready=0 the beat is stored (skid) and count becomes 1.
REQ-022 FALLTHROUGH=0 and count=0: down_valid=0; latency from up_fire to down_valid is exactly 1 cycle.
REQ-023 Simultaneous store and pop at count=DEPTH is impossible (up_ready=0); at 0<count<DEPTH both occur and count is unchanged.
REQ-024 Order preserved: beats leave in acceptance order, none duplicated or dropped.
REQ-025 down_data and down_valid stable while down_valid=1 and down_ready=0 (no retraction).
REQ-026 flush=1: next-edge count=0, rd_ptr=wr_ptr=0, up_ready=1, almost_full=0; down_valid forced 0 during the flush cycle; any up_fire in that cycle is discarded.
REQ-027 flush and rst together: rst takes priority; results identical.
REQ-028 Data array has no reset; only control state is reset.

Reset
REQ-029 While rst=1 at an edge: count=0, pointers=0, up_ready=1, almost_full=0; down_valid=0 from the following cycle.
REQ-030 Reset mid-operation discards all stored beats; the first beat after reset behaves as into an empty buffer.

Verification
REQ-031 DEPTH=4, FALLTHROUGH=1, down_ready=1, stream 0x0001..0x0010 back-to-back -> same-cycle bypass, count=0 throughout, up_ready stays 1.
REQ-032 DEPTH=4, down_ready=0, drive 6 beats -> 4 accepted, count 1,2,3,4, up_ready=0 from cycle after 4th accept, almost_full=1 at count=3 (AF_LEVEL=3).
REQ-033 From full, down_ready=1 with up_valid=1 -> one pop, up_ready=1 next cycle, steady pipelining at count 3/4, pointer wrap 3->0 with order preserved.
REQ-034 FALLTHROUGH=0, single beat 0xBEEF into empty -> down_valid=1 exactly one cycle later with 0xBEEF.
REQ-035 count=3, flush=1 with up_fire 0x1234 -> next cycle count=0, down_valid=0, 0x1234 never appears.
REQ-036 rst asserted at count=2 -> count=0, up_ready=1 next cycle; no stale beats emerge.

Source files
------------

// File: rtl/skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : skid_fifo
// Brief    : Registered-ready FIFO with an optional zero-latency bypass when empty.
// Revision : 1.0 - initial release
// ============================================================================
module skid_fifo #(
    parameter int DW          = 16,
    parameter int DEPTH       = 4,
    parameter int FALLTHROUGH = 1,
    parameter int AF_LEVEL    = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DW-1:0]                up_data,
    input  logic                         up_valid,
    output logic                         up_ready,
    output logic [DW-1:0]                down_data,
    output logic                         down_valid,
    input  logic                         down_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_af    = CW'(AF_LEVEL);
    localparam bit            c_ft    = (FALLTHROUGH != 0);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          up_ready_q, up_ready_d;
    logic          af_q, af_d;

    logic w_empty;
    logic w_up_fire;
    logic w_down_fire;
    logic w_bypass;
    logic w_store;
    logic w_pop;

    always_comb begin
        w_empty     = (count_q == '0);
        w_up_fire   = up_valid && up_ready_q;

        // Flush suppresses the output so nothing escapes while storage is discarded.
        down_valid  = !flush && (!w_empty || (c_ft && up_valid && up_ready_q));
        down_data   = (c_ft && w_empty) ? up_data : mem_q[rd_ptr_q];
        w_down_fire = down_valid && down_ready;

        w_bypass    = c_ft && w_empty && w_down_fire;
        w_store     = w_up_fire && !w_bypass && !flush;
        w_pop       = w_down_fire && !w_empty;
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        up_ready_d = up_ready_q;
        af_d       = af_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_store) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(w_store) - CW'(w_pop);
        end

        // Ready and almost-full look ahead one cycle so both leave the block as flops.
        up_ready_d = (count_d < c_depth);
        af_d       = (count_d >= c_af);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            up_ready_q <= 1'b1;
            af_q       <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            up_ready_q <= up_ready_d;
            af_q       <= af_d;
        end
    end

    // Storage carries no reset; only the control state above defines validity.
    always_ff @(posedge clk) begin
        if (w_store && !rst) begin
            mem_q[wr_ptr_q] <= up_data;
        end
    end

    assign up_ready    = up_ready_q;
    assign count       = count_q;
    assign almost_full = af_q;

endmodule
`default_nettype wire
